fir_stream_driver: RTL and testbench
====================================

Name: fir_stream_driver

Overview:
Host-side initiator for the FIR filter's load/sample handshake. It buffers coefficients and incoming samples, then sequences `load_coeff`/`fir_coefficient` and `data_ready`/`sample_data` into the filter, one item at a time. It paces each item on the filter's `modwait` and captures `fir_out`/`err` after each sample completes. It sits between the test/stream source and the `fir_filter` top.

Parameters:
NUM_COEFF, 4, number of coefficients per load sequence (2..8).
FIFO_DEPTH, 8, sample FIFO entries (power of 2, 2..16).
GUARD_CYC, 2, cycles waited after a strobe before `modwait` is sampled (1..4).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
coeff_in  in  16  coefficient write data.
coeff_wr  in  1  write `coeff_in` to slot `coeff_idx`; `coeff_idx` then increments, wrapping at NUM_COEFF-1.
coeff_go  in  1  request a full coefficient load sequence (one-cycle pulse).
sample_in  in  16  sample write data.
sample_wr  in  1  push `sample_in` into the FIFO.
modwait  in  1  filter busy indicator.
fir_out  in  16  filter result.
err  in  1  filter error flag.
fir_coefficient  out  16  coefficient presented to the filter.
load_coeff  out  1  coefficient strobe.
sample_data  out  16  sample presented to the filter.
data_ready  out  1  sample strobe.
fifo_full  out  1  FIFO full.
busy  out  1  FSM not in IDLE.
coeff_valid  out  1  a complete coefficient set has been loaded since reset.
result_data  out  16  last captured `fir_out`.
result_err  out  1  last captured `err`.
result_valid  out  1  one-cycle pulse when `result_data` updates.
drop_err  out  1  sticky; set when a sample push is refused.
sample_cnt  out  10  completed samples, wraps 1023->0.

Behaviour:
- Reset (async, rst=1):
  - All outputs 0.
  - FIFO emptied; coefficient slots, `coeff_idx` and the pending `coeff_go` latch cleared.
  - FSM forced to IDLE, including mid-sequence; strobes drop immediately.
- FSM states: IDLE, C_STROBE, C_GUARD, C_WAIT, S_STROBE, S_GUARD, S_WAIT, S_CAPTURE.
- IDLE arbitration:
  - A pending `coeff_go` goes to C_STROBE with coefficient index k=0.
  - Otherwise, if `coeff_valid`=1, the FIFO is non-empty and `modwait`=0: pop the FIFO head into the `sample_data` register and go to S_STROBE.
  - Coefficient load has priority over samples.
- C_STROBE:
  - `fir_coefficient`=slot[k]; `load_coeff`=1 for exactly one cycle.
  - Then C_GUARD for GUARD_CYC cycles, then C_WAIT until `modwait`=0.
  - On exit, k+1<NUM_COEFF goes to C_STROBE; else set `coeff_valid` and go to IDLE.
- S_STROBE:
  - `data_ready`=1 for one cycle; `sample_data` held stable from S_STROBE through S_WAIT.
  - Then S_GUARD for GUARD_CYC cycles, then S_WAIT until `modwait`=0, then S_CAPTURE.
- S_CAPTURE (one cycle):
  - `result_data`<=`fir_out`, `result_err`<=`err`.
  - `result_valid`=1 the following cycle; `sample_cnt`+1.
  - Return to IDLE.
- `coeff_go`: latched when seen in any state, cleared on entry to C_STROBE. A request during a sample sequence is served after S_CAPTURE.
- `coeff_wr` during C_* states is ignored (slot and index unchanged). `coeff_wr` in other states takes effect at the next clock.
- FIFO behaviour:
  - Push is accepted iff `fifo_full`=0 at the clock edge.
  - A push while full is dropped and sets `drop_err`; only reset clears `drop_err`.
  - Simultaneous push and pop when full: the pop occurs, the push is refused (no same-cycle slot reuse).
  - Simultaneous push and pop when empty: no pop; the push is stored.
  - Pointers are log2(FIFO_DEPTH)+1 bits, with full/empty derived from the MSB compare.
- `busy`=1 in every state except IDLE.
- Latency: sample pop to `result_valid` is 1 + GUARD_CYC + (modwait-low wait) + 2 cycles. Minimum is 5 with GUARD_CYC=2 and the filter already idle.

Test Plan:
- Write coefficients 0x0001, 0x0002, 0x0003, 0x0004, pulse `coeff_go`, filter model holds `modwait` high 3 cycles per strobe -> exactly 4 `load_coeff` one-cycle pulses with `fir_coefficient` 1,2,3,4 in order, then `coeff_valid`=1 and `busy`=0.
- Push sample 0x1234 before `coeff_valid` is set -> no `data_ready` pulse. After the coefficient load completes, and with the filter model returning 0x00AB with `err`=0 -> `data_ready` pulses once with `sample_data`=0x1234, `result_data`=0x00AB, one `result_valid` pulse, `sample_cnt`=1.
- Push 9 samples (FIFO_DEPTH=8) back-to-back while the FSM is stalled on `modwait`=1 -> `fifo_full`=1 after the 8th push, 9th push dropped with `drop_err`=1; exactly 8 samples are later issued, in push order.
- Pulse `coeff_go` during S_WAIT of a sample -> that sample completes (S_CAPTURE, `result_valid`) before the next `load_coeff` pulse. A sample still in the FIFO waits until after the 4th coefficient.
- Filter model returns `err`=1 -> `result_err`=1 latched alongside `result_data`; the next sample with `err`=0 clears it.
- Assert `rst` mid C_WAIT at k=2 -> all outputs 0 asynchronously, FIFO empty, `coeff_valid`=0; a post-reset `coeff_go` restarts at k=0 using the reset slot values (0x0000).

Source files
------------

// File: rtl/fir_stream_driver.sv
// Host-side sequencer for the FIR filter: buffers coefficients and samples, strobes them
// into the filter one item at a time paced on modwait, and captures each filter result.
module fir_stream_driver #(
    parameter int NUM_COEFF  = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int GUARD_CYC  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] coeff_in,
    input  logic        coeff_wr,
    input  logic        coeff_go,
    input  logic [15:0] sample_in,
    input  logic        sample_wr,
    input  logic        modwait,
    input  logic [15:0] fir_out,
    input  logic        err,
    output logic [15:0] fir_coefficient,
    output logic        load_coeff,
    output logic [15:0] sample_data,
    output logic        data_ready,
    output logic        fifo_full,
    output logic        busy,
    output logic        coeff_valid,
    output logic [15:0] result_data,
    output logic        result_err,
    output logic        result_valid,
    output logic        drop_err,
    output logic [9:0]  sample_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int KW = $clog2(NUM_COEFF);
    localparam logic [KW-1:0] KLast = KW'(NUM_COEFF - 1);
    localparam logic [2:0]    GLast = 3'(GUARD_CYC - 1);

    typedef enum logic [2:0] {
        StIdle,
        StCStrobe,
        StCGuard,
        StCWait,
        StSStrobe,
        StSGuard,
        StSWait,
        StSCapture
    } state_e;

    state_e        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [2:0]    guard_q, guard_d;
    logic          go_pend_q, go_pend_d;
    logic [KW-1:0] coeff_idx_q, coeff_idx_d;
    logic [15:0]   slot_q [NUM_COEFF];
    logic [15:0]   slot_d [NUM_COEFF];
    logic [15:0]   mem_q [FIFO_DEPTH];
    logic [15:0]   mem_d [FIFO_DEPTH];
    logic [AW:0]   wptr_q, wptr_d;
    logic [AW:0]   rptr_q, rptr_d;
    logic [15:0]   sample_q, sample_d;
    logic          coeff_valid_q, coeff_valid_d;
    logic [15:0]   result_data_q, result_data_d;
    logic          result_err_q, result_err_d;
    logic          result_valid_q, result_valid_d;
    logic          drop_err_q, drop_err_d;
    logic [9:0]    sample_cnt_q, sample_cnt_d;

    logic empty, full, push, pop, go_any, in_coeff_seq;

    assign empty  = (wptr_q == rptr_q);
    // Same index with differing wrap bits means the write side has lapped the read side.
    assign full   = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign push   = sample_wr && !full;
    assign go_any = go_pend_q || coeff_go;
    assign pop    = (state_q == StIdle) && !go_any && coeff_valid_q && !empty && !modwait;

    assign in_coeff_seq = (state_q == StCStrobe) || (state_q == StCGuard) ||
                          (state_q == StCWait);

    always_comb begin
        state_d        = state_q;
        k_d            = k_q;
        guard_d        = guard_q;
        sample_d       = sample_q;
        coeff_valid_d  = coeff_valid_q;
        result_data_d  = result_data_q;
        result_err_d   = result_err_q;
        result_valid_d = 1'b0;
        sample_cnt_d   = sample_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (go_any) begin
                    state_d = StCStrobe;
                    k_d     = '0;
                end else if (pop) begin
                    state_d  = StSStrobe;
                    sample_d = mem_q[rptr_q[AW-1:0]];
                end
            end
            StCStrobe: begin
                state_d = StCGuard;
                guard_d = '0;
            end
            StCGuard: begin
                if (guard_q == GLast) begin
                    state_d = StCWait;
                end else begin
                    guard_d = guard_q + 3'd1;
                end
            end
            StCWait: begin
                if (!modwait) begin
                    if (k_q == KLast) begin
                        coeff_valid_d = 1'b1;
                        state_d       = StIdle;
                    end else begin
                        k_d     = k_q + 1'b1;
                        state_d = StCStrobe;
                    end
                end
            end
            StSStrobe: begin
                state_d = StSGuard;
                guard_d = '0;
            end
            StSGuard: begin
                if (guard_q == GLast) begin
                    state_d = StSWait;
                end else begin
                    guard_d = guard_q + 3'd1;
                end
            end
            StSWait: begin
                if (!modwait) begin
                    state_d = StSCapture;
                end
            end
            StSCapture: begin
                result_data_d  = fir_out;
                result_err_d   = err;
                result_valid_d = 1'b1;
                sample_cnt_d   = sample_cnt_q + 10'd1;
                state_d        = StIdle;
            end
        endcase
    end

    // A request arriving in the same cycle as the entry is consumed by that entry.
    assign go_pend_d = go_any && (state_d != StCStrobe);

    always_comb begin
        slot_d      = slot_q;
        coeff_idx_d = coeff_idx_q;
        if (coeff_wr && !in_coeff_seq) begin
            slot_d[coeff_idx_q] = coeff_in;
            coeff_idx_d         = (coeff_idx_q == KLast) ? '0 : coeff_idx_q + 1'b1;
        end
    end

    always_comb begin
        mem_d      = mem_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        drop_err_d = drop_err_q || (sample_wr && full);
        if (push) begin
            mem_d[wptr_q[AW-1:0]] = sample_in;
            wptr_d                = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            k_q            <= '0;
            guard_q        <= '0;
            go_pend_q      <= 1'b0;
            coeff_idx_q    <= '0;
            slot_q         <= '{default: '0};
            mem_q          <= '{default: '0};
            wptr_q         <= '0;
            rptr_q         <= '0;
            sample_q       <= '0;
            coeff_valid_q  <= 1'b0;
            result_data_q  <= '0;
            result_err_q   <= 1'b0;
            result_valid_q <= 1'b0;
            drop_err_q     <= 1'b0;
            sample_cnt_q   <= '0;
        end else begin
            state_q        <= state_d;
            k_q            <= k_d;
            guard_q        <= guard_d;
            go_pend_q      <= go_pend_d;
            coeff_idx_q    <= coeff_idx_d;
            slot_q         <= slot_d;
            mem_q          <= mem_d;
            wptr_q         <= wptr_d;
            rptr_q         <= rptr_d;
            sample_q       <= sample_d;
            coeff_valid_q  <= coeff_valid_d;
            result_data_q  <= result_data_d;
            result_err_q   <= result_err_d;
            result_valid_q <= result_valid_d;
            drop_err_q     <= drop_err_d;
            sample_cnt_q   <= sample_cnt_d;
        end
    end

    // Slots are frozen during a load, so the current slot can drive the filter directly.
    assign fir_coefficient = in_coeff_seq ? slot_q[k_q] : 16'h0000;
    assign load_coeff      = (state_q == StCStrobe);
    assign data_ready      = (state_q == StSStrobe);
    assign sample_data     = sample_q;
    assign fifo_full       = full;
    assign busy            = (state_q != StIdle);
    assign coeff_valid     = coeff_valid_q;
    assign result_data     = result_data_q;
    assign result_err      = result_err_q;
    assign result_valid    = result_valid_q;
    assign drop_err        = drop_err_q;
    assign sample_cnt      = sample_cnt_q;

endmodule

// File: tb/tb_fir_stream_driver.sv
// Randomized bench for fir_stream_driver with a simple filter model and a queue-based
// reference of the expected coefficient and sample streams.
module tb_fir_stream_driver;

    localparam int NC = 4;
    localparam int FD = 8;
    localparam int GC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] coeff_in, sample_in, fir_out;
    logic        coeff_wr, coeff_go, sample_wr, modwait, err;
    logic [15:0] fir_coefficient, sample_data, result_data;
    logic        load_coeff, data_ready, fifo_full, busy, coeff_valid;
    logic        result_err, result_valid, drop_err;
    logic [9:0]  sample_cnt;

    always #5 clk = ~clk;

    fir_stream_driver #(
        .NUM_COEFF (NC),
        .FIFO_DEPTH(FD),
        .GUARD_CYC (GC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .coeff_in       (coeff_in),
        .coeff_wr       (coeff_wr),
        .coeff_go       (coeff_go),
        .sample_in      (sample_in),
        .sample_wr      (sample_wr),
        .modwait        (modwait),
        .fir_out        (fir_out),
        .err            (err),
        .fir_coefficient(fir_coefficient),
        .load_coeff     (load_coeff),
        .sample_data    (sample_data),
        .data_ready     (data_ready),
        .fifo_full      (fifo_full),
        .busy           (busy),
        .coeff_valid    (coeff_valid),
        .result_data    (result_data),
        .result_err     (result_err),
        .result_valid   (result_valid),
        .drop_err       (drop_err),
        .sample_cnt     (sample_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model_out(input logic [15:0] s);
        return (s == 16'h1234) ? 16'h00AB : ((s ^ 16'hA5C3) + 16'd7);
    endfunction

    // Filter stand-in: each strobe makes it busy for 'hold' cycles; 'stall' forces busy.
    int hold  = 3;
    int wcnt  = 0;
    bit stall = 1'b0;
    initial begin
        modwait = 1'b0;
        fir_out = '0;
        err     = 1'b0;
        forever begin
            @(negedge clk);
            if (load_coeff || data_ready) begin
                wcnt = hold;
                if (data_ready) begin
                    fir_out = model_out(sample_data);
                    err     = sample_data[15];
                end
            end else if (wcnt > 0) begin
                wcnt--;
            end
            modwait = stall || (wcnt > 0);
        end
    end

    // Reference state
    logic [15:0] exp_s[$];
    logic [15:0] exp_c[$];
    logic [15:0] ref_slot [NC];
    int          ref_idx = 0;
    int          occ = 0;
    bit          exp_drop = 1'b0;
    int          ref_cnt = 0;
    int          n_load = 0, n_dr = 0, n_rv = 0;
    bit          outstanding = 1'b0;
    bit          prev_load = 1'b0;
    logic [15:0] pend_res;
    logic        pend_err;
    int          cyc = 0, dr_cyc = 0, lat = 0;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        logic [15:0] s;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (load_coeff) begin
                    n_load++;
                    check_eq("load_pulse_width", prev_load, 0);
                    check_eq("load_during_sample", outstanding, 0);
                    if (exp_c.size() > 0) check_eq("fir_coefficient", fir_coefficient,
                                                    exp_c.pop_front());
                    else check_eq("unexpected_load", load_coeff, 0);
                end
                prev_load = load_coeff;
                if (data_ready) begin
                    n_dr++;
                    occ--;
                    dr_cyc = cyc;
                    check_eq("dr_while_coeff_pending", exp_c.size(), 0);
                    if (exp_s.size() > 0) begin
                        s = exp_s.pop_front();
                        check_eq("sample_data", sample_data, s);
                        pend_res    = model_out(s);
                        pend_err    = s[15];
                        outstanding = 1'b1;
                    end else begin
                        check_eq("unexpected_data_ready", data_ready, 0);
                    end
                end
                if (result_valid) begin
                    n_rv++;
                    ref_cnt++;
                    lat = cyc - dr_cyc;
                    check_eq("rv_without_sample", outstanding, 1);
                    check_eq("result_data", result_data, pend_res);
                    check_eq("result_err", result_err, pend_err);
                    check_eq("sample_cnt", sample_cnt, 10'(ref_cnt));
                    outstanding = 1'b0;
                end
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic write_coeff(input logic [15:0] v, input bit tracked);
        coeff_in = v;
        coeff_wr = 1'b1;
        if (tracked) begin
            ref_slot[ref_idx] = v;
            ref_idx = (ref_idx + 1) % NC;
        end
        step();
        coeff_wr = 1'b0;
    endtask

    task automatic go();
        for (int i = 0; i < NC; i++) exp_c.push_back(ref_slot[i]);
        coeff_go = 1'b1;
        step();
        coeff_go = 1'b0;
    endtask

    task automatic push(input logic [15:0] v);
        sample_in = v;
        sample_wr = 1'b1;
        if (occ < FD) begin
            exp_s.push_back(v);
            occ++;
        end else begin
            exp_drop = 1'b1;
        end
        step();
        sample_wr = 1'b0;
    endtask

    task automatic wait_rv(input int target, input int budget);
        for (int i = 0; i < budget && n_rv < target; i++) step();
        check_eq("timeout_result_valid", n_rv >= target, 1);
    endtask

    task automatic wait_dr(input int target, input int budget);
        for (int i = 0; i < budget && n_dr < target; i++) step();
        check_eq("timeout_data_ready", n_dr >= target, 1);
    endtask

    task automatic wait_load(input int target, input int budget);
        for (int i = 0; i < budget && n_load < target; i++) step();
        check_eq("timeout_load_coeff", n_load >= target, 1);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && (busy || !coeff_valid); i++) step();
        check_eq("timeout_idle", busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_l, base_d, base_r;
        logic [15:0] v;

        rst = 1'b1;
        coeff_in = '0; coeff_wr = 1'b0; coeff_go = 1'b0;
        sample_in = '0; sample_wr = 1'b0;
        for (int i = 0; i < NC; i++) ref_slot[i] = '0;
        step(3);
        check_eq("rst_load_coeff", load_coeff, 0);
        check_eq("rst_data_ready", data_ready, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_fifo_full", fifo_full, 0);
        check_eq("rst_coeff_valid", coeff_valid, 0);
        check_eq("rst_result_valid", result_valid, 0);
        check_eq("rst_sample_cnt", sample_cnt, 0);
        check_eq("rst_fir_coefficient", fir_coefficient, 0);
        rst = 1'b0;
        step();

        // Coefficient load with a sample waiting that must not be issued early
        for (int i = 1; i <= NC; i++) write_coeff(16'(i), 1'b1);
        push(16'h1234);
        step(10);
        check_eq("no_dr_before_coeff_valid", n_dr, 0);
        check_eq("coeff_valid_before_go", coeff_valid, 0);
        go();
        for (int i = 0; i < 200 && !coeff_valid; i++) step();
        check_eq("coeff_valid_after_load", coeff_valid, 1);
        check_eq("busy_after_load", busy, 0);
        check_eq("load_count", n_load, NC);
        wait_rv(1, 50);
        check_eq("first_latency", lat, 5);
        check_eq("first_result", result_data, 16'h00AB);
        check_eq("first_cnt", sample_cnt, 1);
        check_eq("first_dr_count", n_dr, 1);

        // Fill the FIFO while the filter is stalled
        stall = 1'b1;
        step(2);
        base_d = n_dr;
        base_r = n_rv;
        for (int i = 0; i < FD + 1; i++) begin
            push(16'($urandom));
            if (i == FD - 1) begin
                check_eq("full_after_depth", fifo_full, 1);
                check_eq("no_drop_yet", drop_err, 0);
            end
        end
        check_eq("drop_err_set", drop_err, exp_drop);
        check_eq("full_still", fifo_full, 1);
        step(3);
        check_eq("no_dr_while_stalled", n_dr, base_d);
        stall = 1'b0;
        wait_rv(base_r + FD, 600);
        check_eq("fifo_drained", fifo_full, 0);
        check_eq("drained_issue_count", n_dr - base_d, FD);
        check_eq("drop_err_sticky", drop_err, 1);

        // Error flag latch and clear
        push(16'h8001);
        wait_rv(n_rv + 1, 60);
        check_eq("err_latched", result_err, 1);
        push(16'h0002);
        wait_rv(n_rv + 1, 60);
        check_eq("err_cleared", result_err, 0);

        // Coefficient request during a sample's wait phase
        hold = 8;
        for (int i = 0; i < NC; i++) write_coeff(16'($urandom), 1'b1);
        base_l = n_load;
        base_r = n_rv;
        push(16'($urandom));
        wait_dr(n_dr + 1, 40);
        step(3);
        go();
        push(16'($urandom));
        wait_load(base_l + 1, 100);
        write_coeff(16'hDEAD, 1'b0);
        wait_rv(base_r + 2, 600);
        check_eq("mid_sample_go_loads", n_load - base_l, NC);
        wait_idle(100);

        // A reload without writes must present the unchanged slots
        hold = 3;
        base_l = n_load;
        go();
        wait_load(base_l + NC, 200);
        wait_idle(100);
        write_coeff(16'h5A5A, 1'b1);
        base_l = n_load;
        go();
        wait_load(base_l + NC, 200);
        wait_idle(100);

        // Randomized sample traffic with varying filter busy time
        for (int it = 0; it < 16; it++) begin
            hold = $urandom_range(0, 5);
            base_r = n_rv;
            push(16'($urandom));
            if ($urandom_range(0, 1) == 1) push(16'($urandom));
            wait_rv(base_r + (n_vec > 0 ? exp_s.size() + int'(outstanding) : 0), 300);
            step($urandom_range(0, 3));
        end
        wait_idle(200);

        // Asynchronous reset mid coefficient wait at k=2
        hold = 8;
        for (int i = 0; i < NC; i++) write_coeff(16'($urandom) | 16'h0001, 1'b1);
        base_l = n_load;
        go();
        push(16'hBEEF);
        wait_load(base_l + 3, 200);
        step(4);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_load_coeff", load_coeff, 0);
        check_eq("arst_busy", busy, 0);
        check_eq("arst_coeff_valid", coeff_valid, 0);
        check_eq("arst_fir_coefficient", fir_coefficient, 0);
        check_eq("arst_drop_err", drop_err, 0);
        check_eq("arst_sample_cnt", sample_cnt, 0);
        check_eq("arst_result_data", result_data, 0);
        check_eq("arst_sample_data", sample_data, 0);
        exp_c.delete();
        exp_s.delete();
        occ = 0;
        ref_cnt = 0;
        outstanding = 1'b0;
        prev_load = 1'b0;
        exp_drop = 1'b0;
        ref_idx = 0;
        for (int i = 0; i < NC; i++) ref_slot[i] = '0;
        step(2);
        rst = 1'b0;
        step();
        hold = 3;
        base_l = n_load;
        base_d = n_dr;
        go();
        wait_load(base_l + NC, 200);
        wait_idle(100);
        check_eq("post_rst_coeff_valid", coeff_valid, 1);
        step(20);
        check_eq("post_rst_fifo_empty", n_dr, base_d);
        v = 16'h0F0F;
        push(v);
        wait_rv(n_rv + 1, 60);
        check_eq("post_rst_cnt", sample_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
